// File: rtl/ddr3_pixel_reader.sv
// Frame reader: issues Avalon-MM burst reads for a packed pixel frame and unpacks
// each 256-bit beat into a pixel stream. Credits cap requests to what the word FIFO can absorb.
module ddr3_pixel_reader #(
  parameter int          pix_width     = 16,
  parameter int          burst_len     = 8,
  parameter int          num_pixels    = 2764800,
  parameter logic [31:0] start_address = 32'h36000000,
  parameter int          fifo_depth    = 32
) (
  input  logic                 ddr3_clk,
  input  logic                 ddr3_clk_reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [26:0]          ddr3_read_address,
  output logic                 ddr3_read,
  output logic [7:0]           ddr3_burstcount,
  input  logic                 ddr3_waitrequest,
  input  logic [255:0]         ddr3_readdata,
  input  logic                 ddr3_readdatavalid,
  output logic [pix_width-1:0] pixel,
  output logic                 pixel_valid,
  input  logic                 pixel_ready,
  output logic [7:0]           fifo_level,
  output logic                 fifo_overflow
);
  localparam int PPW       = 256 / pix_width;
  localparam int NUM_READS = num_pixels / PPW / burst_len;
  localparam int AW        = $clog2(fifo_depth);
  localparam int CW        = AW + 1;
  localparam int RW        = $clog2(NUM_READS + 1);
  localparam int PW        = $clog2(num_pixels + 1);
  localparam int IW        = (PPW > 1) ? $clog2(PPW) : 1;

  localparam logic [CW-1:0] C_BURST   = CW'(burst_len);
  localparam logic [CW-1:0] C_LIMIT   = CW'(fifo_depth - burst_len);
  localparam logic [CW-1:0] C_DEPTH   = CW'(fifo_depth);
  localparam logic [RW-1:0] C_NREADS  = RW'(NUM_READS);
  localparam logic [PW-1:0] C_LASTPIX = PW'(num_pixels - 1);
  localparam logic [IW-1:0] C_LASTIDX = IW'(PPW - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SPACE, ST_ISSUE, ST_DRAIN} state_t;

  state_t         r_state, w_state_nx;
  logic [26:0]    r_addr;
  logic [RW-1:0]  r_reads;
  logic           r_busy;
  logic [CW-1:0]  r_reserved, r_outstanding, r_count;
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [255:0]   r_mem [fifo_depth];
  logic           r_ovf;
  logic [255:0]   r_word;
  logic [IW-1:0]  r_idx;
  logic           r_uvalid;
  logic [PW-1:0]  r_pix_cnt;

  logic w_cmd, w_beat, w_full, w_empty, w_push, w_pop, w_accept, w_credit_ok;

  assign w_cmd       = (r_state == ST_ISSUE) && !ddr3_waitrequest;
  // Beats with nothing outstanding are leftovers from before a reset.
  assign w_beat      = ddr3_readdatavalid && (r_outstanding != '0);
  assign w_full      = (r_count == C_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_push      = w_beat && !w_full;
  assign w_accept    = r_uvalid && pixel_ready;
  assign w_pop       = !w_empty && (!r_uvalid || (w_accept && (r_idx == C_LASTIDX)));
  assign w_credit_ok = (r_reserved <= C_LIMIT);

  always_comb begin
    w_state_nx = r_state;
    ddr3_read  = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      ST_IDLE:       if (start) w_state_nx = ST_WAIT_SPACE;
      ST_WAIT_SPACE: begin
        if (r_reads == C_NREADS) w_state_nx = ST_DRAIN;
        else if (w_credit_ok)    w_state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        ddr3_read = 1'b1;
        if (!ddr3_waitrequest) w_state_nx = ST_WAIT_SPACE;
      end
      ST_DRAIN: begin
        if (w_accept && (r_pix_cnt == C_LASTPIX) && (r_outstanding == '0) && w_empty) begin
          frame_done = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge ddr3_clk or posedge ddr3_clk_reset) begin
    if (ddr3_clk_reset) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_reads       <= '0;
      r_busy        <= 1'b0;
      r_reserved    <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_ovf         <= 1'b0;
      r_word        <= '0;
      r_idx         <= '0;
      r_uvalid      <= 1'b0;
      r_pix_cnt     <= '0;
    end else begin
      r_state <= w_state_nx;
      if ((r_state == ST_IDLE) && start) begin
        r_addr    <= start_address[31:5];
        r_reads   <= '0;
        r_busy    <= 1'b1;
        r_pix_cnt <= '0;
      end
      if (frame_done) r_busy <= 1'b0;
      if (w_cmd) begin
        r_addr  <= r_addr + 27'(burst_len);
        r_reads <= r_reads + RW'(1);
      end
      r_reserved    <= r_reserved + (w_cmd ? C_BURST : '0) - CW'(w_pop);
      r_outstanding <= r_outstanding + (w_cmd ? C_BURST : '0) - CW'(w_beat);
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_beat && w_full) r_ovf <= 1'b1;
      // A refill on the last pixel's accept keeps the stream gap-free across words.
      if (w_pop) begin
        r_word   <= r_mem[r_rptr];
        r_idx    <= '0;
        r_uvalid <= 1'b1;
      end else if (w_accept) begin
        r_word <= r_word >> pix_width;
        r_idx  <= r_idx + IW'(1);
        if (r_idx == C_LASTIDX) r_uvalid <= 1'b0;
      end
      if (w_accept) r_pix_cnt <= r_pix_cnt + PW'(1);
    end
  end

  always_ff @(posedge ddr3_clk) begin
    if (w_push) r_mem[r_wptr] <= ddr3_readdata;
  end

  assign busy              = r_busy;
  assign ddr3_read_address = r_addr;
  assign ddr3_burstcount   = 8'(burst_len);
  assign pixel             = r_word[pix_width-1:0];
  assign pixel_valid       = r_uvalid;
  assign fifo_level        = 8'(r_count);
  assign fifo_overflow     = r_ovf;
endmodule

// File: tb/tb_ddr3_pixel_reader.sv
// Randomized bench: an Avalon burst-read slave serves a synthetic frame whose pixel
// values are a known function of frame and index; the pixel stream is checked against it.
module tb_ddr3_pixel_reader;
  localparam int PW = 16, BL = 8, NPIX = 1024, FD = 32;
  localparam int PPW = 256 / PW, NREADS = NPIX / PPW / BL;
  localparam logic [26:0] BASE = 27'h1B00000;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic          busy, frame_done, ddr3_read, ddr3_waitrequest, ddr3_readdatavalid;
  logic [26:0]   ddr3_read_address;
  logic [7:0]    ddr3_burstcount, fifo_level;
  logic [255:0]  ddr3_readdata;
  logic [PW-1:0] pixel;
  logic          pixel_valid, pixel_ready, fifo_overflow;

  ddr3_pixel_reader #(.pix_width(PW), .burst_len(BL), .num_pixels(NPIX),
                      .start_address(32'h36000000), .fifo_depth(FD)) dut (
    .ddr3_clk(clk), .ddr3_clk_reset(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .ddr3_read_address(ddr3_read_address), .ddr3_read(ddr3_read), .ddr3_burstcount(ddr3_burstcount),
    .ddr3_waitrequest(ddr3_waitrequest), .ddr3_readdata(ddr3_readdata),
    .ddr3_readdatavalid(ddr3_readdatavalid), .pixel(pixel), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .fifo_level(fifo_level), .fifo_overflow(fifo_overflow));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int wr_pct = 0, beat_pct = 100, lat = 1, rdy_pct = 100;
  bit beat_en = 1'b1, start_req = 1'b0;
  int q_off[$], q_ep[$], q_due[$];
  int cur_ep = -1, ep_next = 0, pix_idx = 0, n_cmds = 0, fd_cnt = 0, out_words = 0, req_words = 0;
  bit busy_m = 1'b0, took_prev = 1'b0, fd_prev = 1'b0, fd_seen = 1'b0;
  bit prev_vld = 1'b0, prev_acc = 1'b0;
  logic [PW-1:0] prev_pix;
  logic [26:0]   addr0, addr1;
  logic [PW-1:0] first_pix[32];
  int            acc_cyc[32];

  // Memory image: pixel idx of frame ep carries the frame number in its top nibble.
  function automatic logic [PW-1:0] pixval(int ep, int idx);
    return PW'(idx) ^ PW'(ep << 12);
  endfunction

  function automatic logic [255:0] mkword(int ep, int off);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < PPW; k++) w[k*PW +: PW] = pixval(ep, off * PPW + k);
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic acc, fd_exp, took;
    @(negedge clk);
    cyc++;
    if (fd_prev) busy_m = 1'b0;
    if (took_prev) busy_m = 1'b1;
    // slave: command acceptance takes effect at the coming posedge
    ddr3_waitrequest = ($urandom_range(99) < wr_pct);
    if (!rst && ddr3_read && !ddr3_waitrequest) begin
      chk("cmd_addr", ddr3_read_address, BASE + 27'(n_cmds * BL));
      chk("burstcount", ddr3_burstcount, BL);
      if (n_cmds == 0) addr0 = ddr3_read_address;
      if (n_cmds == 1) addr1 = ddr3_read_address;
      for (int b = 0; b < BL; b++) begin
        q_off.push_back(n_cmds * BL + b); q_ep.push_back(cur_ep); q_due.push_back(cyc + lat);
      end
      n_cmds++; req_words += BL; out_words += BL;
    end
    if (beat_en && q_off.size() > 0 && q_due[0] <= cyc && $urandom_range(99) < beat_pct) begin
      ddr3_readdatavalid = 1'b1;
      ddr3_readdata = mkword(q_ep[0], q_off[0]);
      if (q_ep[0] == cur_ep) out_words--;
      void'(q_off.pop_front()); void'(q_ep.pop_front()); void'(q_due.pop_front());
    end else begin
      ddr3_readdatavalid = 1'b0;
      ddr3_readdata = {8{$urandom()}};
    end
    start = start_req; start_req = 1'b0;
    took = start && !busy_m && !rst;
    if (took) begin
      cur_ep = ep_next; ep_next++;
      pix_idx = 0; n_cmds = 0; fd_cnt = 0; out_words = 0; req_words = 0;
    end
    pixel_ready = ($urandom_range(99) < rdy_pct);
    #1;
    acc = pixel_valid && pixel_ready;
    fd_exp = acc && (pix_idx == NPIX - 1);
    chk("frame_done", frame_done, fd_exp);
    if (acc) begin
      chk("pixel", pixel, pixval(cur_ep, pix_idx));
      if (pix_idx < 32) begin first_pix[pix_idx] = pixel; acc_cyc[pix_idx] = cyc; end
      pix_idx++;
    end
    if (prev_vld && !prev_acc) begin
      chk("hold_valid", pixel_valid, 1);
      chk("hold_pixel", pixel, prev_pix);
    end
    if (!busy_m) chk("idle_no_pixel", pixel_valid, 0);
    prev_vld = pixel_valid; prev_acc = acc; prev_pix = pixel;
    chk("busy", busy, busy_m);
    chk("overflow", fifo_overflow, 0);
    chk("fifo_level_bound", fifo_level <= 8'(FD), 1);
    chk("outstanding_bound", out_words <= FD, 1);
    if (fd_exp) begin fd_cnt++; fd_seen = 1'b1; end
    fd_prev = fd_exp; took_prev = took;
  endtask

  task automatic do_reset();
    rst = 1'b1; beat_en = 1'b0;
    busy_m = 1'b0; cur_ep = -1; pix_idx = 0; n_cmds = 0; out_words = 0; req_words = 0;
    prev_vld = 1'b0; fd_prev = 1'b0; took_prev = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_read", ddr3_read, 0);
    chk("rst_addr", ddr3_read_address, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_overflow", fifo_overflow, 0);
  endtask

  task automatic wait_frame(input int budget, input string name);
    int n;
    n = 0;
    while (!fd_seen && n < budget) begin tick(); n++; end
    checks++;
    if (!fd_seen) begin errors++; $display("FAIL %s_timeout: got no frame_done after %0d cycles", name, n); end
    chk("num_bursts", n_cmds, NREADS);
    chk("pixels_out", pix_idx, NPIX);
    repeat (10) tick();
    chk("frame_done_once", fd_cnt, 1);
    chk("idle_after_frame", busy, 0);
  endtask

  task automatic run_frame(input int budget, input string name);
    fd_seen = 1'b0; start_req = 1'b1;
    wait_frame(budget, name);
  endtask

  initial begin
    int n;
    ddr3_waitrequest = 1'b0; ddr3_readdatavalid = 1'b0; ddr3_readdata = '0; pixel_ready = 1'b0;
    do_reset(); beat_en = 1'b1;

    // single frame, ready always high, random waitrequest; first two words checked literally
    wr_pct = 40; lat = 1; beat_pct = 100; rdy_pct = 100;
    run_frame(8000, "frame1");
    chk("addr_burst0", addr0, 27'h1B00000);
    chk("addr_burst1", addr1, 27'h1B00008);
    chk("word0_pix1", first_pix[1], 16'h0001);
    chk("word1_pix17", first_pix[17], 16'h0011);
    chk("word1_pix31", first_pix[31], 16'h001F);
    chk("no_bubble", acc_cyc[31] - acc_cyc[0], 31);

    // backpressure: sink stalled, requests must stop at the FIFO capacity
    wr_pct = 30; lat = 5; rdy_pct = 0;
    fd_seen = 1'b0; start_req = 1'b1;
    repeat (500) tick();
    chk("stall_words_requested", req_words, 32);
    chk("stall_fifo_level", fifo_level, 31);
    chk("stall_all_returned", out_words, 0);
    rdy_pct = 70;
    wait_frame(20000, "backpressure");

    // long read latency, beats bunched together
    wr_pct = 20; lat = 40; beat_pct = 100; rdy_pct = 60;
    run_frame(20000, "latency");

    // start while busy is ignored
    wr_pct = 25; lat = 3; rdy_pct = 80;
    fd_seen = 1'b0; start_req = 1'b1;
    repeat (100) tick();
    start_req = 1'b1;
    repeat (50) tick();
    start_req = 1'b1;
    wait_frame(20000, "restart_ignored");

    // reset with 5 beats of a burst still due; they arrive after reset and must vanish
    wr_pct = 0; lat = 3; beat_pct = 100; rdy_pct = 0;
    fd_seen = 1'b0; start_req = 1'b1;
    n = 0;
    while (!(n_cmds >= 1 && q_off.size() == 5) && n < 500) begin tick(); n++; end
    chk("reached_5_due", q_off.size(), 5);
    do_reset();
    beat_en = 1'b1;
    repeat (20) tick();
    chk("stale_delivered", q_off.size(), 0);
    chk("stale_dropped_level", fifo_level, 0);
    chk("stale_no_pixel", pixel_valid, 0);
    wr_pct = 30; lat = 2; rdy_pct = 90;
    run_frame(20000, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
